tl_tlp_tx: RTL and testbench

//  Read side of the TL buffering path. Drains a header FIFO and a payload FIFO, both

---
 rtl/tl_tlp_tx.sv | 138 +++++++++++++
 tb/tb_tl_tlp_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_tlp_tx.sv
// tl_tlp_tx: drains the TL header/payload FIFO pair and reframes each TLP
// as a registered valid/ready beat stream (header beat, then payload beats)
// toward the DLL transmit side.
module tl_tlp_tx #(
    parameter int DATA_WIDTH = 256,
    parameter int HDR_WIDTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hdr_empty_i,
    output logic                  hdr_rden_o,
    input  logic [HDR_WIDTH-1:0]  hdr_rdata_i,
    input  logic                  pld_empty_i,
    output logic                  pld_rden_o,
    input  logic [DATA_WIDTH-1:0] pld_rdata_i,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_sop_o,
    output logic                  tx_eop_o,
    output logic [31:0]           tlp_cnt_o
);
    localparam int          DW_PER_BEAT = DATA_WIDTH / 32;
    localparam int          BEAT_SHIFT  = $clog2(DW_PER_BEAT);
    localparam logic [10:0] BEAT_ROUND  = 11'(DW_PER_BEAT - 1);

    typedef enum logic {S_IDLE, S_PAYLOAD} state_t;

    state_t                 state_q, state_d;
    logic [10:0]            rem_q, rem_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                   tx_sop_q, tx_sop_d;
    logic                   tx_eop_q, tx_eop_d;
    logic [31:0]            tlp_cnt_q, tlp_cnt_d;

    logic        ld;
    logic        hdr_load, pld_load;
    logic        has_data;
    logic [10:0] len_dw;
    logic [10:0] beats;

    // Output register may take a new beat when empty or being drained this cycle.
    assign ld       = ~tx_valid_q | tx_ready_i;
    assign has_data = hdr_rdata_i[30];
    // A zero length field encodes the 1024 DW maximum.
    assign len_dw   = {(hdr_rdata_i[9:0] == 10'd0), hdr_rdata_i[9:0]};
    assign beats    = (len_dw + BEAT_ROUND) >> BEAT_SHIFT;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: header with data opens a payload phase, last payload beat closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (hdr_load && has_data)        state_d = S_PAYLOAD;
            S_PAYLOAD: if (pld_load && rem_q == 11'd1)  state_d = S_IDLE;
            default:                                    state_d = S_IDLE;
        endcase
    end

    // FSM outputs: FIFO pops, gated by reset so nothing is consumed while in reset.
    always_comb begin
        hdr_load = 1'b0;
        pld_load = 1'b0;
        case (state_q)
            S_IDLE:    hdr_load = rst_n & ld & ~hdr_empty_i;
            S_PAYLOAD: pld_load = rst_n & ld & ~pld_empty_i;
            default:   ;
        endcase
    end

    assign hdr_rden_o = hdr_load;
    assign pld_rden_o = pld_load;

    // Beat datapath: load header or payload beat, or bubble when nothing is ready.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_sop_d   = tx_sop_q;
        tx_eop_d   = tx_eop_q;
        rem_d      = rem_q;
        if (ld) begin
            if (hdr_load) begin
                tx_valid_d = 1'b1;
                tx_data_d  = DATA_WIDTH'(hdr_rdata_i);
                tx_sop_d   = 1'b1;
                tx_eop_d   = ~has_data;
                rem_d      = beats;
            end else if (pld_load) begin
                tx_valid_d = 1'b1;
                tx_data_d  = pld_rdata_i;
                tx_sop_d   = 1'b0;
                tx_eop_d   = (rem_q == 11'd1);
                rem_d      = rem_q - 11'd1;
            end else begin
                // Data is left as-is; only valid drops.
                tx_valid_d = 1'b0;
            end
        end
    end

    // Completed-TLP counter, free-running with natural wrap.
    always_comb begin
        tlp_cnt_d = tlp_cnt_q;
        if (tx_valid_q && tx_ready_i && tx_eop_q) tlp_cnt_d = tlp_cnt_q + 32'd1;
    end

    // Datapath registers; reset drops any partially sent TLP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
            rem_q      <= '0;
            tlp_cnt_q  <= '0;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_sop_q   <= tx_sop_d;
            tx_eop_q   <= tx_eop_d;
            rem_q      <= rem_d;
            tlp_cnt_q  <= tlp_cnt_d;
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign tx_sop_o   = tx_sop_q;
    assign tx_eop_o   = tx_eop_q;
    assign tlp_cnt_o  = tlp_cnt_q;

endmodule

// File: tb/tb_tl_tlp_tx.sv
// tb_tl_tlp_tx: directed vectors against tl_tlp_tx with queue-based FIFO models.
module tb_tl_tlp_tx;
    localparam int DW = 256;
    localparam int HW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hdr_empty_i, hdr_rden_o;
    logic [HW-1:0] hdr_rdata_i;
    logic          pld_empty_i, pld_rden_o;
    logic [DW-1:0] pld_rdata_i;
    logic          tx_valid_o, tx_ready_i;
    logic [DW-1:0] tx_data_o;
    logic          tx_sop_o, tx_eop_o;
    logic [31:0]   tlp_cnt_o;

    tl_tlp_tx #(.DATA_WIDTH(DW), .HDR_WIDTH(HW)) dut (
        .clk(clk), .rst_n(rst_n),
        .hdr_empty_i(hdr_empty_i), .hdr_rden_o(hdr_rden_o), .hdr_rdata_i(hdr_rdata_i),
        .pld_empty_i(pld_empty_i), .pld_rden_o(pld_rden_o), .pld_rdata_i(pld_rdata_i),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
        .tx_sop_o(tx_sop_o), .tx_eop_o(tx_eop_o), .tlp_cnt_o(tlp_cnt_o)
    );

    always #5 clk = ~clk;

    logic [HW-1:0] hq[$];
    logic [DW-1:0] pq[$];
    logic [DW-1:0] log_d[$];
    logic          log_s[$];
    logic          log_e[$];
    int n_hr, n_pr, n_both, n_bad;
    int n_chk, n_pass;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [HW-1:0] mk_hdr(input logic hd, input logic [9:0] len, input logic [31:0] tag);
        logic [HW-1:0] h;
        h = '0;
        h[127:96] = tag;
        h[30] = hd;
        h[9:0] = len;
        return h;
    endfunction

    function automatic logic [DW-1:0] mk_pld(input logic [31:0] v);
        logic [DW-1:0] p;
        p = {8{v}};
        return p;
    endfunction

    task automatic upd_fifo();
        hdr_empty_i = (hq.size() == 0);
        hdr_rdata_i = (hq.size() != 0) ? hq[0] : '0;
        pld_empty_i = (pq.size() == 0);
        pld_rdata_i = (pq.size() != 0) ? pq[0] : '0;
    endtask

    // One clock: sample pops and accepted beats before the edge, apply pops after.
    task automatic tick();
        logic hr, pr;
        upd_fifo();
        #1;
        hr = hdr_rden_o;
        pr = pld_rden_o;
        if (hr) n_hr++;
        if (pr) n_pr++;
        if (hr && pr) n_both++;
        if ((hr && hdr_empty_i) || (pr && pld_empty_i)) n_bad++;
        if (tx_valid_o && tx_ready_i) begin
            log_d.push_back(tx_data_o);
            log_s.push_back(tx_sop_o);
            log_e.push_back(tx_eop_o);
        end
        @(posedge clk);
        #1;
        if (hr && hq.size() != 0) void'(hq.pop_front());
        if (pr && pq.size() != 0) void'(pq.pop_front());
        upd_fifo();
    endtask

    task automatic clr();
        log_d.delete(); log_s.delete(); log_e.delete();
        n_hr = 0; n_pr = 0;
    endtask

    logic [HW-1:0] h;
    logic [DW-1:0] sd;
    logic          ss, se, sv;
    int            hr0, pr0, eops;

    initial begin
        n_chk = 0; n_pass = 0; n_both = 0; n_bad = 0;
        rst_n = 1'b0;
        tx_ready_i = 1'b1;
        clr();
        // reset: header present, no pop allowed
        hq.push_back(mk_hdr(1'b0, 10'd1, 32'hdead));
        tick(); tick();
        chk("rst_rden", DW'(hdr_rden_o), '0);
        chk("rst_valid", DW'(tx_valid_o), '0);
        chk("rst_sop_eop", DW'({tx_sop_o, tx_eop_o}), '0);
        chk("rst_data", tx_data_o, '0);
        chk("rst_cnt", DW'(tlp_cnt_o), '0);
        hq.delete();
        rst_n = 1'b1;
        tick();
        clr();

        // 1: MRd, single beat
        h = mk_hdr(1'b0, 10'd1, 32'h1111);
        hq.push_back(h);
        tick();
        chk("t1_lat_valid", DW'(tx_valid_o), DW'(1));
        tick(); tick(); tick();
        chk("t1_nbeats", DW'(log_d.size()), DW'(1));
        chk("t1_beat", {log_d[0][DW-3:0], log_s[0], log_e[0]}, {DW'(h), 2'b11} >> 0 & {DW{1'b1}});
        chk("t1_hdr_rden", DW'(n_hr), DW'(1));
        chk("t1_pld_rden", DW'(n_pr), DW'(0));
        chk("t1_cnt", DW'(tlp_cnt_o), DW'(1));
        clr();

        // 2: MWr len 10 -> header + 2 payload; third queued entry must stay
        h = mk_hdr(1'b1, 10'd10, 32'h2222);
        hq.push_back(h);
        pq.push_back(mk_pld(32'ha0)); pq.push_back(mk_pld(32'ha1)); pq.push_back(mk_pld(32'ha2));
        repeat (6) tick();
        chk("t2_nbeats", DW'(log_d.size()), DW'(3));
        chk("t2_sop", DW'({log_s[0], log_s[1], log_s[2]}), DW'(3'b100));
        chk("t2_eop", DW'({log_e[0], log_e[1], log_e[2]}), DW'(3'b001));
        chk("t2_d0", log_d[0], DW'(h));
        chk("t2_d2", log_d[2], mk_pld(32'ha1));
        chk("t2_pld_rden", DW'(n_pr), DW'(2));
        chk("t2_left", DW'(pq.size()), DW'(1));
        chk("t2_cnt", DW'(tlp_cnt_o), DW'(2));
        pq.delete();
        clr();

        // 3: MWr len 0 -> 1024 DW -> 128 payload beats
        hq.push_back(mk_hdr(1'b1, 10'd0, 32'h3333));
        for (int i = 0; i < 128; i++) pq.push_back(mk_pld(32'(i)));
        repeat (140) tick();
        eops = 0;
        foreach (log_e[i]) if (log_e[i]) eops++;
        chk("t3_nbeats", DW'(log_d.size()), DW'(129));
        chk("t3_eops", DW'(eops), DW'(1));
        chk("t3_last", {log_d[128][DW-3:0], log_s[128], log_e[128]}, {mk_pld(32'd127), 2'b01} & {DW{1'b1}});
        chk("t3_pld_rden", DW'(n_pr), DW'(128));
        chk("t3_cnt", DW'(tlp_cnt_o), DW'(3));
        clr();

        // 4: 5-cycle stall mid-payload (len 24 -> 3 payload beats)
        hq.push_back(mk_hdr(1'b1, 10'd24, 32'h4444));
        pq.push_back(mk_pld(32'hb0)); pq.push_back(mk_pld(32'hb1)); pq.push_back(mk_pld(32'hb2));
        tick(); tick();
        tx_ready_i = 1'b0;
        sd = tx_data_o; ss = tx_sop_o; se = tx_eop_o; sv = tx_valid_o;
        hr0 = n_hr; pr0 = n_pr;
        repeat (5) tick();
        chk("t4_hold", {tx_data_o[DW-4:0], tx_valid_o, tx_sop_o, tx_eop_o}, {sd[DW-4:0], sv, ss, se});
        chk("t4_held_beat", tx_data_o, mk_pld(32'hb0));
        chk("t4_stall_rden", DW'((n_hr - hr0) + (n_pr - pr0)), DW'(0));
        tx_ready_i = 1'b1;
        repeat (6) tick();
        chk("t4_nbeats", DW'(log_d.size()), DW'(4));
        chk("t4_last", {log_d[3][DW-3:0], log_e[3]} , {mk_pld(32'hb2), 1'b1} & {(DW-1){1'b1}});
        chk("t4_cnt", DW'(tlp_cnt_o), DW'(4));
        clr();

        // 5: payload FIFO runs dry after first of 2 beats (len 16)
        hq.push_back(mk_hdr(1'b1, 10'd16, 32'h5555));
        pq.push_back(mk_pld(32'hc0));
        tick(); tick(); tick();
        chk("t5_bubble", DW'(tx_valid_o), DW'(0));
        pr0 = n_pr;
        repeat (3) tick();
        chk("t5_bubble_hold", {tx_data_o[DW-2:0], tx_valid_o}, {mk_pld(32'hc0), 1'b0} & {DW{1'b1}});
        chk("t5_empty_rden", DW'(n_pr - pr0), DW'(0));
        pq.push_back(mk_pld(32'hc1));
        repeat (3) tick();
        chk("t5_nbeats", DW'(log_d.size()), DW'(3));
        chk("t5_eop", DW'({log_e[0], log_e[1], log_e[2]}), DW'(3'b001));
        chk("t5_d2", log_d[2], mk_pld(32'hc1));
        chk("t5_cnt", DW'(tlp_cnt_o), DW'(5));
        clr();

        // 6: back-to-back MRd, then reset in the middle of an MWr
        hq.push_back(mk_hdr(1'b0, 10'd1, 32'h6661));
        hq.push_back(mk_hdr(1'b0, 10'd2, 32'h6662));
        tick();
        chk("t6_h1", {tx_data_o[DW-2:0], tx_sop_o}, {DW'(mk_hdr(1'b0, 10'd1, 32'h6661)), 1'b1} & {DW{1'b1}});
        tick();
        chk("t6_h2", {tx_data_o[DW-3:0], tx_valid_o, tx_sop_o}, {DW'(mk_hdr(1'b0, 10'd2, 32'h6662)), 2'b11} & {DW{1'b1}});
        tick();
        chk("t6_cnt", DW'(tlp_cnt_o), DW'(7));
        hq.push_back(mk_hdr(1'b1, 10'd24, 32'h6663));
        pq.push_back(mk_pld(32'hd0)); pq.push_back(mk_pld(32'hd1)); pq.push_back(mk_pld(32'hd2));
        tick(); tick();
        rst_n = 1'b0;
        upd_fifo();
        #1;
        chk("t6_rst_rden", DW'({hdr_rden_o, pld_rden_o}), '0);
        tick();
        chk("t6_rst_valid", DW'(tx_valid_o), DW'(0));
        chk("t6_rst_cnt", DW'(tlp_cnt_o), DW'(0));
        hq.delete(); pq.delete();
        rst_n = 1'b1;
        h = mk_hdr(1'b0, 10'd1, 32'h6664);
        hq.push_back(h);
        tick();
        chk("t6_restart", {tx_data_o[DW-3:0], tx_valid_o, tx_sop_o}, {DW'(h), 2'b11} & {DW{1'b1}});

        chk("rden_both", DW'(n_both), DW'(0));
        chk("rden_empty", DW'(n_bad), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
